// File: rtl/hybrid_noc_output_stage_v2_if.sv
// Link bundle of one router output stage: TDM and BE inputs, the merged output link,
// the schedule-LUT configuration port and slot realignment.
interface hybrid_noc_output_stage_v2_if #(
    parameter int FLIT_WIDTH = 34,
    parameter int PORTS      = 5,
    parameter int BE_PORTS   = 5,
    parameter int LUT_SIZE   = 16
);
    logic [PORTS*FLIT_WIDTH-1:0]    tdm_in_flit;
    logic [PORTS-1:0]               tdm_in_valid;
    logic [PORTS-1:0]               tdm_in_last;
    logic [BE_PORTS*FLIT_WIDTH-1:0] be_in_flit;
    logic [BE_PORTS-1:0]            be_in_valid;
    logic [BE_PORTS-1:0]            be_in_last;
    logic [BE_PORTS-1:0]            be_in_ready;
    logic [FLIT_WIDTH-1:0]          out_flit;
    logic                           out_last;
    logic                           tdm_out_valid;
    logic                           be_out_valid;
    logic                           be_out_ready;
    logic [$clog2(PORTS+1)-1:0]     lut_conf_data;
    logic [$clog2(PORTS)-1:0]       lut_conf_sel;
    logic [$clog2(LUT_SIZE)-1:0]    lut_conf_slot;
    logic                           lut_conf_valid;
    logic                           slot_sync;
    logic                           tdm_collision;

    modport master (
        output tdm_in_flit, tdm_in_valid, tdm_in_last,
        output be_in_flit, be_in_valid, be_in_last, be_out_ready,
        output lut_conf_data, lut_conf_sel, lut_conf_slot, lut_conf_valid, slot_sync,
        input  be_in_ready, out_flit, out_last, tdm_out_valid, be_out_valid, tdm_collision
    );

    modport slave (
        input  tdm_in_flit, tdm_in_valid, tdm_in_last,
        input  be_in_flit, be_in_valid, be_in_last, be_out_ready,
        input  lut_conf_data, lut_conf_sel, lut_conf_slot, lut_conf_valid, slot_sync,
        output be_in_ready, out_flit, out_last, tdm_out_valid, be_out_valid, tdm_collision
    );
endinterface

// File: rtl/hybrid_noc_output_stage_v2.sv
// Hybrid NoC output port: LUT-scheduled TDM flits merged with round-robin, packet-locked
// best-effort flits onto one link. TDM is registered (latency 1) and always preempts BE.
module hybrid_noc_output_stage_v2 #(
    parameter int FLIT_WIDTH   = 34,
    parameter int PORTS        = 5,
    parameter int BE_PORTS     = 5,
    parameter int LUT_SIZE     = 16,
    parameter int OUTPUT_ID    = 0,
    parameter int BUFFER_DEPTH = 2,
    parameter int BE_ENABLED   = 1,
    parameter int SLOT_REUSE   = 1
) (
    input logic clk,
    input logic rst,
    hybrid_noc_output_stage_v2_if.slave link
);
    localparam int SEL_W  = $clog2(PORTS + 1);
    localparam int CSEL_W = $clog2(PORTS);
    localparam int SLOT_W = $clog2(LUT_SIZE);
    localparam int BP_W   = (BE_PORTS > 1) ? $clog2(BE_PORTS) : 1;
    localparam int PTR_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W  = $clog2(BUFFER_DEPTH + 1);
    localparam logic [SEL_W-1:0] UNRES = SEL_W'(PORTS);
    localparam logic BE_ON = (BE_ENABLED != 0);
    localparam logic REUSE = (SLOT_REUSE != 0);

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [SEL_W-1:0]      lut_q [LUT_SIZE];
    logic [SEL_W-1:0]      sel;
    logic                  lut_we;

    logic [FLIT_WIDTH-1:0] tdm_flit_q, tdm_flit_d;
    logic                  tdm_valid_q, tdm_valid_d;
    logic                  tdm_last_q, tdm_last_d;
    logic                  coll_q, coll_d;
    logic                  rsvd_q, rsvd_d;

    logic [FLIT_WIDTH:0]   fifo_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BP_W-1:0]       ptr_q, ptr_d, grant_q, grant_d;
    logic                  lock_q, lock_d;

    logic                  arb_found;
    logic [BP_W-1:0]       arb_idx, g;
    logic                  granted, full, push, pop, be_valid, reuse_ok;
    logic                  in_valid_g, in_last_g;
    logic [FLIT_WIDTH-1:0] in_flit_g;
    logic [FLIT_WIDTH:0]   head;
    logic [BE_PORTS-1:0]   be_ready;

    assign slot_d = link.slot_sync ? '0 : slot_q + SLOT_W'(1);
    assign sel    = lut_q[slot_q];
    assign lut_we = link.lut_conf_valid && (link.lut_conf_sel == CSEL_W'(OUTPUT_ID));
    assign rsvd_d = (sel != UNRES);

    always_comb begin
        tdm_valid_d = 1'b0;
        tdm_flit_d  = '0;
        tdm_last_d  = 1'b0;
        coll_d      = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel == SEL_W'(i)) begin
                tdm_valid_d = link.tdm_in_valid[i];
                tdm_flit_d  = link.tdm_in_valid[i] ? link.tdm_in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] : '0;
                tdm_last_d  = link.tdm_in_valid[i] & link.tdm_in_last[i];
            end else if (link.tdm_in_valid[i]) begin
                coll_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            tdm_valid_q <= 1'b0;
            tdm_flit_q  <= '0;
            tdm_last_q  <= 1'b0;
            coll_q      <= 1'b0;
            rsvd_q      <= 1'b0;
            for (int i = 0; i < LUT_SIZE; i++) lut_q[i] <= UNRES;
        end else begin
            slot_q      <= slot_d;
            tdm_valid_q <= tdm_valid_d;
            tdm_flit_q  <= tdm_flit_d;
            tdm_last_q  <= tdm_last_d;
            coll_q      <= coll_d;
            rsvd_q      <= rsvd_d;
            if (lut_we) lut_q[link.lut_conf_slot] <= link.lut_conf_data;
        end
    end

    // Rotating priority: first valid input at or after the pointer, wrapping.
    always_comb begin
        int c;
        c         = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < BE_PORTS; i++) begin
            c = int'(ptr_q) + i;
            if (c >= BE_PORTS) c = c - BE_PORTS;
            if (!arb_found && link.be_in_valid[c]) begin
                arb_found = 1'b1;
                arb_idx   = BP_W'(c);
            end
        end
    end

    assign g       = lock_q ? grant_q : arb_idx;
    assign granted = lock_q | arb_found;

    always_comb begin
        in_valid_g = 1'b0;
        in_last_g  = 1'b0;
        in_flit_g  = '0;
        for (int i = 0; i < BE_PORTS; i++) begin
            if (g == BP_W'(i)) begin
                in_valid_g = link.be_in_valid[i];
                in_last_g  = link.be_in_last[i];
                in_flit_g  = link.be_in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_comb begin
        be_ready = '0;
        for (int i = 0; i < BE_PORTS; i++) begin
            be_ready[i] = BE_ON ? (~rst & granted & ~full & (g == BP_W'(i))) : 1'b1;
        end
    end

    assign full     = (cnt_q == CNT_W'(BUFFER_DEPTH));
    assign push     = BE_ON & ~rst & granted & ~full & in_valid_g;
    assign head     = fifo_q[rd_q];
    assign reuse_ok = REUSE | ~rsvd_q;
    assign be_valid = BE_ON & ~rst & (cnt_q != '0) & ~tdm_valid_q & reuse_ok;
    assign pop      = be_valid & link.be_out_ready;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        lock_d  = lock_q;
        if (push) begin
            wr_d = (wr_q == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            if (in_last_g) begin
                lock_d = 1'b0;
                ptr_d  = (g == BP_W'(BE_PORTS - 1)) ? '0 : g + BP_W'(1);
            end else begin
                lock_d  = 1'b1;
                grant_d = g;
            end
        end
        if (pop) rd_d = (rd_q == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= {in_last_g, in_flit_g};
    end

    always_comb begin
        link.out_flit = '0;
        link.out_last = 1'b0;
        if (tdm_valid_q) begin
            link.out_flit = tdm_flit_q;
            link.out_last = tdm_last_q;
        end else if (be_valid) begin
            link.out_flit = head[FLIT_WIDTH-1:0];
            link.out_last = head[FLIT_WIDTH];
        end
    end

    assign link.be_in_ready   = be_ready;
    assign link.tdm_out_valid = tdm_valid_q;
    assign link.be_out_valid  = be_valid;
    assign link.tdm_collision = coll_q;
endmodule

// File: tb/tb_hybrid_noc_output_stage_v2.sv
// Scoreboard bench for the hybrid NoC output stage: a slot-reuse instance carries the
// main traffic, a strict-slot twin shares its TDM/LUT inputs for the reuse-policy check.
module tb_hybrid_noc_output_stage_v2;
    localparam int FW = 34;
    localparam int P  = 5;
    localparam int BP = 5;
    localparam int LS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hybrid_noc_output_stage_v2_if #(.FLIT_WIDTH(FW), .PORTS(P), .BE_PORTS(BP), .LUT_SIZE(LS)) bus1 ();
    hybrid_noc_output_stage_v2_if #(.FLIT_WIDTH(FW), .PORTS(P), .BE_PORTS(BP), .LUT_SIZE(LS)) bus2 ();

    hybrid_noc_output_stage_v2 #(
        .FLIT_WIDTH(FW), .PORTS(P), .BE_PORTS(BP), .LUT_SIZE(LS), .OUTPUT_ID(0),
        .BUFFER_DEPTH(2), .BE_ENABLED(1), .SLOT_REUSE(1)
    ) dut (.clk(clk), .rst(rst), .link(bus1));

    hybrid_noc_output_stage_v2 #(
        .FLIT_WIDTH(FW), .PORTS(P), .BE_PORTS(BP), .LUT_SIZE(LS), .OUTPUT_ID(0),
        .BUFFER_DEPTH(2), .BE_ENABLED(1), .SLOT_REUSE(0)
    ) dut_nr (.clk(clk), .rst(rst), .link(bus2));

    assign bus2.tdm_in_flit    = bus1.tdm_in_flit;
    assign bus2.tdm_in_valid   = bus1.tdm_in_valid;
    assign bus2.tdm_in_last    = bus1.tdm_in_last;
    assign bus2.lut_conf_data  = bus1.lut_conf_data;
    assign bus2.lut_conf_sel   = bus1.lut_conf_sel;
    assign bus2.lut_conf_slot  = bus1.lut_conf_slot;
    assign bus2.lut_conf_valid = bus1.lut_conf_valid;
    assign bus2.slot_sync      = bus1.slot_sync;
    assign bus2.be_out_ready   = 1'b0;

    typedef struct packed {
        logic          tdm;
        logic          last;
        logic [FW-1:0] flit;
    } exp_t;

    exp_t        exp_q[$];
    logic [FW:0] src_q[BP][$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic tdm, input logic [FW-1:0] flit, input logic last);
        exp_t e;
        e.tdm  = tdm;
        e.last = last;
        e.flit = flit;
        exp_q.push_back(e);
    endtask

    task automatic be_pkt(input int port, input logic [FW-1:0] base, input int n);
        for (int k = 0; k < n; k++) src_q[port].push_back({(k == n - 1), base + FW'(k)});
    endtask

    task automatic lut_wr(input int osel, input int slot, input int data);
        bus1.lut_conf_valid = 1'b1;
        bus1.lut_conf_sel   = 3'(osel);
        bus1.lut_conf_slot  = 4'(slot);
        bus1.lut_conf_data  = 3'(data);
        step();
        bus1.lut_conf_valid = 1'b0;
    endtask

    task automatic align();
        bus1.slot_sync = 1'b1;
        step();
        bus1.slot_sync = 1'b0;
    endtask

    task automatic tdm_inject(input int port, input logic [FW-1:0] flit, input logic last,
                              input logic expect_out);
        bus1.tdm_in_valid[port]            = 1'b1;
        bus1.tdm_in_last[port]             = last;
        bus1.tdm_in_flit[port*FW +: FW]    = flit;
        if (expect_out) exp_push(1'b1, flit, last);
        step();
        bus1.tdm_in_valid = '0;
        bus1.tdm_in_last  = '0;
        bus1.tdm_in_flit  = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // BE sources: present queue head, advance when the handshake completed last cycle.
    initial begin
        logic [BP-1:0] fire;
        logic [FW:0]   h;
        bus1.be_in_valid = '0;
        bus1.be_in_flit  = '0;
        bus1.be_in_last  = '0;
        forever begin
            @(negedge clk);
            fire = bus1.be_in_valid & bus1.be_in_ready;
            @(posedge clk);
            #2;
            for (int p = 0; p < BP; p++) begin
                if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    h = src_q[p][0];
                    bus1.be_in_valid[p]       = 1'b1;
                    bus1.be_in_last[p]        = h[FW];
                    bus1.be_in_flit[p*FW +: FW] = h[FW-1:0];
                end else begin
                    bus1.be_in_valid[p]       = 1'b0;
                    bus1.be_in_last[p]        = 1'b0;
                    bus1.be_in_flit[p*FW +: FW] = '0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus1.tdm_out_valid || (bus1.be_out_valid && bus1.be_out_ready))) begin
                if (exp_q.size() == 0) begin
                    check("sb_expected_output", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind_tdm", bus1.tdm_out_valid, e.tdm);
                    check("out_flit", bus1.out_flit, e.flit);
                    check("out_last", bus1.out_last, e.last);
                end
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus1.tdm_in_flit    = '0;
        bus1.tdm_in_valid   = '0;
        bus1.tdm_in_last    = '0;
        bus1.be_out_ready   = 1'b0;
        bus1.lut_conf_valid = 1'b0;
        bus1.lut_conf_sel   = '0;
        bus1.lut_conf_slot  = '0;
        bus1.lut_conf_data  = '0;
        bus1.slot_sync      = 1'b0;
        bus2.be_in_valid    = '0;
        bus2.be_in_flit     = '0;
        bus2.be_in_last     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_be_in_ready", bus1.be_in_ready, 0);
        check("rst_tdm_out_valid", bus1.tdm_out_valid, 0);
        check("rst_be_out_valid", bus1.be_out_valid, 0);
        check("rst_out_flit", bus1.out_flit, 0);
        check("rst_out_last", bus1.out_last, 0);
        check("rst_tdm_collision", bus1.tdm_collision, 0);
        step();
        rst = 1'b0;

        // TDM hit on reserved slot 3; write to another output id must be ignored
        lut_wr(0, 3, 2);
        lut_wr(1, 3, 0);
        align();
        repeat (3) step();
        tdm_inject(2, 34'h0A5, 1'b1, 1'b1);
        @(negedge clk);
        check("tdm_hit_collision", bus1.tdm_collision, 0);
        wait_drain("tdm_hit_drain", 4);

        // TDM flit from the wrong input in slot 3 is dropped
        align();
        repeat (3) step();
        tdm_inject(1, 34'h011, 1'b0, 1'b0);
        @(negedge clk);
        check("tdm_miss_collision", bus1.tdm_collision, 1);
        check("tdm_miss_valid", bus1.tdm_out_valid, 0);
        step();
        @(negedge clk);
        check("collision_pulse_end", bus1.tdm_collision, 0);

        // Two competing 3-flit packets: input 0 whole, then input 3 whole
        step();
        bus1.be_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_push(1'b0, 34'h100 + FW'(k), (k == 2));
        for (int k = 0; k < 3; k++) exp_push(1'b0, 34'h300 + FW'(k), (k == 2));
        be_pkt(0, 34'h100, 3);
        be_pkt(3, 34'h300, 3);
        wait_drain("be_rr_drain", 40);
        // pointer now 4: input 4 wins over input 3
        be_pkt(3, 34'h310, 1);
        be_pkt(4, 34'h410, 1);
        exp_push(1'b0, 34'h410, 1'b1);
        exp_push(1'b0, 34'h310, 1'b1);
        wait_drain("be_ptr_drain", 20);

        // Backpressure with a 2-deep FIFO
        bus1.be_out_ready = 1'b0;
        be_pkt(1, 34'h200, 4);
        for (int k = 0; k < 4; k++) exp_push(1'b0, 34'h200 + FW'(k), (k == 3));
        repeat (6) step();
        @(negedge clk);
        check("bp_ready_low", bus1.be_in_ready, 0);
        check("bp_accepted", src_q[1].size(), 2);
        check("bp_head_valid", bus1.be_out_valid, 1);
        step();
        bus1.be_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_per_cycle", bus1.be_out_valid, 1);
            step();
        end
        @(negedge clk);
        check("drain_done", bus1.be_out_valid, 0);
        check("drain_sb", exp_q.size(), 0);

        // Slot reuse policy: slot 5 reserved for idle input 0
        step();
        lut_wr(0, 5, 0);
        bus2.be_in_valid[0]   = 1'b1;
        bus2.be_in_last[0]    = 1'b1;
        bus2.be_in_flit[FW-1:0] = 34'h555;
        step();
        bus2.be_in_valid = '0;
        bus1.be_out_ready = 1'b0;
        be_pkt(2, 34'h222, 1);
        exp_push(1'b0, 34'h222, 1'b1);
        align();
        repeat (5) step();
        step();
        @(negedge clk);
        check("nr_reserved_idle", bus2.be_out_valid, 0);
        check("sr_reserved_idle", bus1.be_out_valid, 1);
        step();
        @(negedge clk);
        check("nr_unreserved", bus2.be_out_valid, 1);
        check("nr_head_flit", bus2.out_flit, 34'h555);
        step();
        bus1.be_out_ready = 1'b1;
        wait_drain("sr_drain", 10);

        // slot_sync at slot 9 -> slot 0 next cycle
        step();
        lut_wr(0, 0, 4);
        align();
        repeat (9) step();
        bus1.slot_sync = 1'b1;
        step();
        bus1.slot_sync = 1'b0;
        tdm_inject(4, 34'h044, 1'b0, 1'b1);
        @(negedge clk);
        check("sync_collision", bus1.tdm_collision, 0);
        wait_drain("sync_drain", 4);

        // LUT write to the current slot: old entry this cycle, new entry next period
        align();
        repeat (7) step();
        bus1.lut_conf_valid = 1'b1;
        bus1.lut_conf_sel   = 3'd0;
        bus1.lut_conf_slot  = 4'd7;
        bus1.lut_conf_data  = 3'd1;
        tdm_inject(1, 34'h077, 1'b1, 1'b0);
        bus1.lut_conf_valid = 1'b0;
        @(negedge clk);
        check("wr_cur_collision", bus1.tdm_collision, 1);
        check("wr_cur_valid", bus1.tdm_out_valid, 0);
        repeat (15) step();
        tdm_inject(1, 34'h078, 1'b0, 1'b1);
        @(negedge clk);
        check("wr_next_collision", bus1.tdm_collision, 0);
        wait_drain("wr_next_drain", 4);

        // Reset in the middle of a locked, backpressured packet
        step();
        bus1.be_out_ready = 1'b0;
        be_pkt(0, 34'h600, 3);
        repeat (4) step();
        rst = 1'b1;
        src_q[0].delete();
        @(negedge clk);
        check("rst_mid_ready", bus1.be_in_ready, 0);
        check("rst_mid_be_valid", bus1.be_out_valid, 0);
        check("rst_mid_out_flit", bus1.out_flit, 0);
        check("rst_mid_tdm_valid", bus1.tdm_out_valid, 0);
        step();
        step();
        rst = 1'b0;
        align();
        tdm_inject(4, 34'h099, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_lut_collision", bus1.tdm_collision, 1);
        check("post_rst_lut_valid", bus1.tdm_out_valid, 0);
        check("post_rst_fifo_empty", bus1.be_out_valid, 0);
        step();
        be_pkt(3, 34'h333, 1);
        exp_push(1'b0, 34'h333, 1'b1);
        bus1.be_out_ready = 1'b1;
        wait_drain("post_rst_unlocked", 20);

        repeat (3) step();
        check("sb_empty_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hybrid_noc_output_stage_v2.md
Name: hybrid_noc_output_stage_v2

Overview:
Next-generation output port of the hybrid TDM/BE NoC router, instantiated once per active output link. It merges LUT-scheduled TDM traffic with round-robin-arbitrated, packet-locked BE traffic onto one link. New relative to the current output stage: a slot-sync input, a selectable BE slot-reuse policy, and a TDM collision flag for the control network.

Parameters:
FLIT_WIDTH, 34, flit width including parity bits
PORTS, 5, number of TDM inputs
BE_PORTS, 5, number of BE inputs
LUT_SIZE, 16, TDM slots per period (power of two, >=2)
OUTPUT_ID, 0, index compared against lut_conf_sel
BUFFER_DEPTH, 2, BE FIFO depth (>=2)
BE_ENABLED, 1, 0 = port carries TDM only
SLOT_REUSE, 1, 1 = BE may use any cycle with no TDM flit; 0 = BE only in unreserved slots

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tdm_in_flit  in  PORTS*FLIT_WIDTH  TDM flits, all inputs
tdm_in_valid  in  PORTS  TDM valid per input
tdm_in_last  in  PORTS  TDM last per input
be_in_flit  in  BE_PORTS*FLIT_WIDTH  BE flits
be_in_valid  in  BE_PORTS  BE valid, requesting this output
be_in_last  in  BE_PORTS  BE last
be_in_ready  out  BE_PORTS  BE accept
out_flit  out  FLIT_WIDTH  link flit
out_last  out  1  link last
tdm_out_valid  out  1  link carries TDM flit
be_out_valid  out  1  link carries BE flit
be_out_ready  in  1  downstream BE accept
lut_conf_data  in  $clog2(PORTS+1)  LUT entry value; PORTS = unreserved
lut_conf_sel  in  $clog2(PORTS)  target output
lut_conf_slot  in  $clog2(LUT_SIZE)  target slot
lut_conf_valid  in  1  LUT write strobe
slot_sync  in  1  realign slot counter
tdm_collision  out  1  one-cycle pulse: TDM flit on unreserved input dropped

Behaviour:
- Clocking: single clock clk. Reset rst is synchronous and active-high.
- Reset values: slot counter 0; all LUT entries PORTS; BE FIFO empty; arbiter pointer 0; lock clear; outputs tdm_out_valid=0, be_out_valid=0, out_flit=0, out_last=0, tdm_collision=0.
- be_in_ready during reset: 0 if BE_ENABLED=1, all 1 if BE_ENABLED=0.
- Reset mid-packet: discards FIFO contents and lock; no partial-packet recovery.
- Slot counter: increments every cycle, wrapping LUT_SIZE-1 -> 0. When slot_sync=1, the next value is 0; slot_sync takes priority over the increment.
- LUT write: when lut_conf_valid && lut_conf_sel==OUTPUT_ID, lut[lut_conf_slot] <= lut_conf_data. The write takes effect from the next cycle. If the write targets the current slot, that cycle still uses the old entry.
- TDM path, latency 1:
  - sel = lut[slot]. If sel<PORTS and tdm_in_valid[sel]=1, next cycle tdm_out_valid=1, out_flit=tdm_in_flit[sel], out_last=tdm_in_last[sel].
  - TDM has no backpressure.
  - Any tdm_in_valid[i]=1 with i!=sel: that flit is dropped and tdm_collision=1 next cycle.
- BE input arbiter:
  - Rotating priority starting at pointer; grants the lowest valid index >= pointer, wrapping.
  - Grant is evaluated only when unlocked.
  - be_in_ready[g] = granted & FIFO not full & BE_ENABLED; all other ready bits are 0.
  - Accepting a non-last flit sets the lock on g. Accepting a last flit clears the lock and sets pointer = g+1 mod BE_PORTS.
  - While locked, only g is ready, even if other inputs are valid.
- BE FIFO:
  - Push on accept; pop on be_out_valid && be_out_ready.
  - Full: ready=0. A push while full is not allowed, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when non-full and non-empty: count unchanged.
- BE output, combinational from FIFO head and registered TDM state:
  - be_out_valid = BE_ENABLED & FIFO non-empty & ~tdm_out_valid & reuse_ok.
  - reuse_ok = 1 if SLOT_REUSE=1. Otherwise reuse_ok = (lut[registered slot of output cycle]==PORTS).
  - When be_out_valid=1: out_flit/out_last come from the FIFO head.
  - When no TDM flit and no BE flit: out_flit=0, out_last=0.
  - TDM always preempts BE. A waiting BE head is held, not dropped.
- BE_ENABLED=0: FIFO and arbiter are absent; be_out_valid=0; be_in_ready all 1 (flits discarded).

Test Plan:
- LUT slot 3 = input 2, others PORTS; inject TDM flit 0xA5 on input 2 during slot 3 -> tdm_out_valid=1, out_flit=0xA5 one cycle later; tdm_collision stays 0.
- Same LUT; inject TDM on input 1 during slot 3 -> flit dropped, tdm_out_valid=0, tdm_collision pulses one cycle.
- Inputs 0 and 3 send 3-flit BE packets simultaneously, be_out_ready=1 -> all three flits of input 0 are output, then all three of input 3; no interleaving; pointer then = 4.
- be_out_ready=0 with BUFFER_DEPTH=2 -> two flits accepted, then be_in_ready=0. Raise be_out_ready -> one flit drains per cycle.
- SLOT_REUSE=0, slot 5 reserved but idle, BE pending -> be_out_valid=0 in that output cycle. Same stimulus with SLOT_REUSE=1 -> be_out_valid=1.
- Assert slot_sync when slot=9 -> slot=0 next cycle. LUT write to the current slot -> old entry applies that cycle, new entry from the next period. Assert rst mid-packet -> all outputs 0, LUT all PORTS.
